decode_stage: RTL and testbench

- ID stage of the pipelined CPU. Sits directly upstream of regfile.
- Accepts fetched instructions over a valid/ready handshake and drives ReadRegister1/ReadRegister2 combinationally from rs/rt.
- Captures ReadData1/ReadData2, the extended immediate and control fields into the ID/EX register that feeds execute.
- Detects load-use hazards and inserts one bubble per hazard.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/instr_decoder.sv | 106 ++++++++++
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_decode_stage.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU pipeline stages.
// Holds the opcode and funct encodings that decode recognises, the link
// register index used by JAL, and a helper that tells whether an opcode
// reads the rt register as a source operand.
// No ports (package).
package cpu_pkg;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_J     = 6'h02;
  localparam opcode_t OP_JAL   = 6'h03;
  localparam opcode_t OP_BEQ   = 6'h04;
  localparam opcode_t OP_BNE   = 6'h05;
  localparam opcode_t OP_ADDI  = 6'h08;
  localparam opcode_t OP_ADDIU = 6'h09;
  localparam opcode_t OP_SLTI  = 6'h0A;
  localparam opcode_t OP_ANDI  = 6'h0C;
  localparam opcode_t OP_ORI   = 6'h0D;
  localparam opcode_t OP_XORI  = 6'h0E;
  localparam opcode_t OP_LUI   = 6'h0F;
  localparam opcode_t OP_LW    = 6'h23;
  localparam opcode_t OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR = 6'h08;

  localparam logic [4:0] REG_RA = 5'd31;

  // rt is a true source for R-type ALU ops, store data and branch compares;
  // for every other format it is a destination or unused.
  function automatic logic readsRt(input opcode_t op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational decode of one instruction's fields
// into the control information carried by the ID/EX register.
// Ports:
//   i_opcode  in   6       Instr[31:26]
//   i_funct   in   6       Instr[5:0]
//   i_rt      in   ADDR_W  Instr[20:16]
//   i_rd      in   ADDR_W  Instr[15:11]
//   i_imm     in   16      Instr[15:0]
//   o_dest    out  ADDR_W  destination register (0 when nothing is written)
//   o_regWrite out 1       instruction writes the regfile
//   o_memRead out  1       load
//   o_memWrite out 1       store
//   o_imm     out  DATA_W  sign/zero/upper extended immediate
//   o_usesRt  out  1       rt is read as a source operand
//   o_illegal out  1       opcode not recognised
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [5:0]        i_opcode,
  input  logic [5:0]        i_funct,
  input  logic [ADDR_W-1:0] i_rt,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [15:0]       i_imm,
  output logic [ADDR_W-1:0] o_dest,
  output logic              o_regWrite,
  output logic              o_memRead,
  output logic              o_memWrite,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_usesRt,
  output logic              o_illegal
);

  logic [DATA_W-1:0] w_signExt;
  logic [DATA_W-1:0] w_zeroExt;
  logic [DATA_W-1:0] w_upperImm;

  assign w_signExt  = {{(DATA_W-16){i_imm[15]}}, i_imm};
  assign w_zeroExt  = {{(DATA_W-16){1'b0}}, i_imm};
  assign w_upperImm = {i_imm, {(DATA_W-16){1'b0}}};

  // Map the opcode to destination, control bits and immediate form. Every
  // output gets a safe default first so unlisted opcodes decode as an inert
  // illegal instruction. A destination of r0 can never be written, so the
  // write enable is dropped for it after the case.
  always_comb begin
    o_dest     = '0;
    o_regWrite = 1'b0;
    o_memRead  = 1'b0;
    o_memWrite = 1'b0;
    o_imm      = '0;
    o_illegal  = 1'b0;
    o_usesRt   = readsRt(i_opcode);

    case (i_opcode)
      OP_RTYPE: begin
        o_dest     = i_rd;
        o_regWrite = (i_funct != FN_JR);
      end
      OP_LW: begin
        o_dest     = i_rt;
        o_regWrite = 1'b1;
        o_memRead  = 1'b1;
        o_imm      = w_signExt;
      end
      OP_SW: begin
        o_memWrite = 1'b1;
        o_imm      = w_signExt;
      end
      OP_BEQ, OP_BNE: begin
        o_imm = w_signExt;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        o_dest     = i_rt;
        o_regWrite = 1'b1;
        o_imm      = w_signExt;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        o_dest     = i_rt;
        o_regWrite = 1'b1;
        o_imm      = w_zeroExt;
      end
      OP_LUI: begin
        o_dest     = i_rt;
        o_regWrite = 1'b1;
        o_imm      = w_upperImm;
      end
      OP_J: begin
      end
      OP_JAL: begin
        o_dest     = ADDR_W'(REG_RA);
        o_regWrite = 1'b1;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase

    if (o_dest == '0) begin
      o_regWrite = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage of the pipelined CPU, directly upstream of regfile.
// Accepts instructions on a valid/ready handshake, drives the regfile read
// addresses straight from rs/rt, and captures operands, immediate and
// control into the ID/EX register. A load followed by a dependent
// instruction gets exactly one bubble; bubbles are counted (saturating).
// Optional feature macro: DECODE_WB_BYPASS_EN -- when defined, a writeback
// to rs/rt in the same cycle replaces the regfile read data.
// Ports:
//   Clk, reset (sync, active-high)
//   Instr/InstrValid/InstrReady   instruction handshake from fetch
//   Flush                         squash ID/EX (branch mispredict)
//   ReadRegister1/2, ReadData1/2  regfile read ports
//   WbRegWrite/WbWriteRegister/WbWriteData  writeback snoop
//   ExReady/ExValid and Ex*       ID/EX register towards execute
//   StallCount                    saturating count of inserted bubbles
module decode_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      Instr,
  input  logic                   InstrValid,
  output logic                   InstrReady,
  input  logic                   Flush,
  output logic [ADDR_W-1:0]      ReadRegister1,
  output logic [ADDR_W-1:0]      ReadRegister2,
  input  logic [DATA_W-1:0]      ReadData1,
  input  logic [DATA_W-1:0]      ReadData2,
  input  logic                   WbRegWrite,
  input  logic [ADDR_W-1:0]      WbWriteRegister,
  input  logic [DATA_W-1:0]      WbWriteData,
  input  logic                   ExReady,
  output logic                   ExValid,
  output logic [DATA_W-1:0]      ExOpA,
  output logic [DATA_W-1:0]      ExOpB,
  output logic [DATA_W-1:0]      ExImm,
  output logic [ADDR_W-1:0]      ExDestReg,
  output logic                   ExRegWrite,
  output logic                   ExMemRead,
  output logic                   ExMemWrite,
  output logic [5:0]             ExOpcode,
  output logic [5:0]             ExFunct,
  output logic                   ExIllegal,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_dest;
  logic              w_regWrite;
  logic              w_memRead;
  logic              w_memWrite;
  logic [DATA_W-1:0] w_imm;
  logic              w_usesRt;
  logic              w_illegal;
  logic              w_advance;
  logic              w_hazard;
  logic [DATA_W-1:0] w_opA;
  logic [DATA_W-1:0] w_opB;

  logic                   r_exValid;
  logic [DATA_W-1:0]      r_exOpA;
  logic [DATA_W-1:0]      r_exOpB;
  logic [DATA_W-1:0]      r_exImm;
  logic [ADDR_W-1:0]      r_exDestReg;
  logic                   r_exRegWrite;
  logic                   r_exMemRead;
  logic                   r_exMemWrite;
  logic [5:0]             r_exOpcode;
  logic [5:0]             r_exFunct;
  logic                   r_exIllegal;
  logic [STALL_CNT_W-1:0] r_stallCount;

  assign w_rs = Instr[25:21];
  assign w_rt = Instr[20:16];
  assign w_rd = Instr[15:11];

  assign ReadRegister1 = w_rs;
  assign ReadRegister2 = w_rt;

  instr_decoder #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_instrDecoder (
    .i_opcode   (Instr[31:26]),
    .i_funct    (Instr[5:0]),
    .i_rt       (w_rt),
    .i_rd       (w_rd),
    .i_imm      (Instr[15:0]),
    .o_dest     (w_dest),
    .o_regWrite (w_regWrite),
    .o_memRead  (w_memRead),
    .o_memWrite (w_memWrite),
    .o_imm      (w_imm),
    .o_usesRt   (w_usesRt),
    .o_illegal  (w_illegal)
  );

`ifdef DECODE_WB_BYPASS_EN
  // The regfile write lands at the end of this cycle, so its read port still
  // shows the old value; forward the in-flight writeback data instead.
  assign w_opA = (WbRegWrite && (WbWriteRegister != '0) && (WbWriteRegister == w_rs))
                 ? WbWriteData : ReadData1;
  assign w_opB = (WbRegWrite && (WbWriteRegister != '0) && (WbWriteRegister == w_rt))
                 ? WbWriteData : ReadData2;
`else
  logic w_unusedWb;
  assign w_unusedWb = ^{WbRegWrite, WbWriteRegister, WbWriteData};
  assign w_opA      = ReadData1;
  assign w_opB      = ReadData2;
`endif

  // ID/EX may take new contents when it is empty or execute is draining it.
  assign w_advance = !r_exValid || ExReady;

  // A load sitting in ID/EX cannot forward its data in time for the next
  // instruction, so any read of its destination must wait one cycle. r0 is
  // never a real dependency.
  assign w_hazard = InstrValid && r_exValid && r_exMemRead && (r_exDestReg != '0) &&
                    ((r_exDestReg == w_rs) || (w_usesRt && (r_exDestReg == w_rt)));

  assign InstrReady = w_advance && !w_hazard && !Flush;

  // ID/EX register and bubble counter. Flush wins over everything but reset;
  // a hazard loads a bubble with all side-effect controls cleared; otherwise
  // the decoded instruction is loaded whenever ID/EX is free to advance.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_exValid    <= 1'b0;
      r_exOpA      <= '0;
      r_exOpB      <= '0;
      r_exImm      <= '0;
      r_exDestReg  <= '0;
      r_exRegWrite <= 1'b0;
      r_exMemRead  <= 1'b0;
      r_exMemWrite <= 1'b0;
      r_exOpcode   <= '0;
      r_exFunct    <= '0;
      r_exIllegal  <= 1'b0;
      r_stallCount <= '0;
    end else if (Flush) begin
      r_exValid    <= 1'b0;
      r_exRegWrite <= 1'b0;
      r_exMemRead  <= 1'b0;
      r_exMemWrite <= 1'b0;
    end else if (w_advance) begin
      if (w_hazard) begin
        r_exValid    <= 1'b0;
        r_exRegWrite <= 1'b0;
        r_exMemRead  <= 1'b0;
        r_exMemWrite <= 1'b0;
        if (r_stallCount != '1) begin
          r_stallCount <= r_stallCount + STALL_CNT_W'(1);
        end
      end else begin
        r_exValid    <= InstrValid;
        r_exOpA      <= w_opA;
        r_exOpB      <= w_opB;
        r_exImm      <= w_imm;
        r_exDestReg  <= w_dest;
        r_exRegWrite <= w_regWrite;
        r_exMemRead  <= w_memRead;
        r_exMemWrite <= w_memWrite;
        r_exOpcode   <= Instr[31:26];
        r_exFunct    <= Instr[5:0];
        r_exIllegal  <= w_illegal;
      end
    end
  end

  assign ExValid    = r_exValid;
  assign ExOpA      = r_exOpA;
  assign ExOpB      = r_exOpB;
  assign ExImm      = r_exImm;
  assign ExDestReg  = r_exDestReg;
  assign ExRegWrite = r_exRegWrite;
  assign ExMemRead  = r_exMemRead;
  assign ExMemWrite = r_exMemWrite;
  assign ExOpcode   = r_exOpcode;
  assign ExFunct    = r_exFunct;
  assign ExIllegal  = r_exIllegal;
  assign StallCount = r_stallCount;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage. Directed
// instruction sequences drive the stage; a behavioural model built from the
// instruction-set table and the handshake/hazard rules predicts the ID/EX
// contents, InstrReady and StallCount, compared every negative edge. A few
// hand-computed literal expectations pin the model.
// Optional feature macro: DECODE_WB_BYPASS_EN (changes the bypass expectation).
module tb_decode_stage;

  logic        Clk;
  logic        reset;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        InstrReady;
  logic        Flush;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        WbRegWrite;
  logic [4:0]  WbWriteRegister;
  logic [31:0] WbWriteData;
  logic        ExReady;
  logic        ExValid;
  logic [31:0] ExOpA;
  logic [31:0] ExOpB;
  logic [31:0] ExImm;
  logic [4:0]  ExDestReg;
  logic        ExRegWrite;
  logic        ExMemRead;
  logic        ExMemWrite;
  logic [5:0]  ExOpcode;
  logic [5:0]  ExFunct;
  logic        ExIllegal;
  logic [15:0] StallCount;

  int checks   = 0;
  int failures = 0;
  bit running  = 1'b1;

  logic [31:0] regs [32];

  decode_stage #(
    .DATA_W      (32),
    .ADDR_W      (5),
    .STALL_CNT_W (16)
  ) dut (
    .Clk             (Clk),
    .reset           (reset),
    .Instr           (Instr),
    .InstrValid      (InstrValid),
    .InstrReady      (InstrReady),
    .Flush           (Flush),
    .ReadRegister1   (ReadRegister1),
    .ReadRegister2   (ReadRegister2),
    .ReadData1       (ReadData1),
    .ReadData2       (ReadData2),
    .WbRegWrite      (WbRegWrite),
    .WbWriteRegister (WbWriteRegister),
    .WbWriteData     (WbWriteData),
    .ExReady         (ExReady),
    .ExValid         (ExValid),
    .ExOpA           (ExOpA),
    .ExOpB           (ExOpB),
    .ExImm           (ExImm),
    .ExDestReg       (ExDestReg),
    .ExRegWrite      (ExRegWrite),
    .ExMemRead       (ExMemRead),
    .ExMemWrite      (ExMemWrite),
    .ExOpcode        (ExOpcode),
    .ExFunct         (ExFunct),
    .ExIllegal       (ExIllegal),
    .StallCount      (StallCount)
  );

  // Free-running clock, first rising edge at 5.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Regfile stand-in: reads follow the addresses the DUT presents.
  assign ReadData1 = regs[ReadRegister1];
  assign ReadData2 = regs[ReadRegister2];

  typedef struct {
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        illegal;
  } exp_t;

  exp_t        mEx;
  logic        mValid;
  logic [15:0] mStall;

  // Instruction-set table: what each opcode must place into ID/EX.
  function automatic exp_t refDecode(input logic [31:0] ins);
    exp_t e;
    logic [15:0] imm16;
    imm16      = ins[15:0];
    e.opA      = 32'h0;
    e.opB      = 32'h0;
    e.imm      = 32'h0;
    e.dest     = 5'd0;
    e.regWrite = 1'b0;
    e.memRead  = 1'b0;
    e.memWrite = 1'b0;
    e.opcode   = ins[31:26];
    e.funct    = ins[5:0];
    e.illegal  = 1'b0;
    case (ins[31:26])
      6'h00: begin e.dest = ins[15:11]; e.regWrite = (ins[5:0] != 6'h08); end
      6'h23: begin e.dest = ins[20:16]; e.regWrite = 1'b1; e.memRead = 1'b1;
                   e.imm = {{16{imm16[15]}}, imm16}; end
      6'h2B: begin e.memWrite = 1'b1; e.imm = {{16{imm16[15]}}, imm16}; end
      6'h04, 6'h05: e.imm = {{16{imm16[15]}}, imm16};
      6'h08, 6'h09, 6'h0A: begin e.dest = ins[20:16]; e.regWrite = 1'b1;
                   e.imm = {{16{imm16[15]}}, imm16}; end
      6'h0C, 6'h0D, 6'h0E: begin e.dest = ins[20:16]; e.regWrite = 1'b1;
                   e.imm = {16'h0, imm16}; end
      6'h0F: begin e.dest = ins[20:16]; e.regWrite = 1'b1; e.imm = {imm16, 16'h0}; end
      6'h02: ;
      6'h03: begin e.dest = 5'd31; e.regWrite = 1'b1; end
      default: e.illegal = 1'b1;
    endcase
    if (e.dest == 5'd0) e.regWrite = 1'b0;
    return e;
  endfunction

  function automatic logic rtIsSource(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
  endfunction

  function automatic logic [31:0] operandFor(input logic [4:0] r);
`ifdef DECODE_WB_BYPASS_EN
    if (WbRegWrite && WbWriteRegister != 5'd0 && WbWriteRegister == r) return WbWriteData;
`endif
    return regs[r];
  endfunction

  function automatic logic modelHazard();
    return InstrValid && mValid && mEx.memRead && (mEx.dest != 5'd0) &&
           ((mEx.dest == Instr[25:21]) ||
            (rtIsSource(Instr[31:26]) && (mEx.dest == Instr[20:16])));
  endfunction

  function automatic logic modelReady();
    return (!mValid || ExReady) && !modelHazard() && !Flush;
  endfunction

  // Model update on every rising edge, from the handshake and hazard rules.
  initial begin
    mValid = 1'b0;
    mStall = 16'h0;
    mEx    = refDecode(32'h0);
  end

  always @(posedge Clk) begin
    if (reset) begin
      mValid = 1'b0;
      mStall = 16'h0;
    end else if (Flush) begin
      mValid = 1'b0;
    end else if (!mValid || ExReady) begin
      if (modelHazard()) begin
        mValid = 1'b0;
        if (mStall != 16'hFFFF) mStall = mStall + 16'h1;
      end else begin
        mEx     = refDecode(Instr);
        mEx.opA = operandFor(Instr[25:21]);
        mEx.opB = operandFor(Instr[20:16]);
        mValid  = InstrValid;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (running) begin
      checkOutput("ExValid", 32'(ExValid), 32'(mValid));
      checkOutput("StallCount", 32'(StallCount), 32'(mStall));
      checkOutput("InstrReady", 32'(InstrReady), 32'(modelReady()));
      checkOutput("ReadRegister1", 32'(ReadRegister1), 32'(Instr[25:21]));
      checkOutput("ReadRegister2", 32'(ReadRegister2), 32'(Instr[20:16]));
      if (mValid) begin
        checkOutput("ExOpA", ExOpA, mEx.opA);
        checkOutput("ExOpB", ExOpB, mEx.opB);
        checkOutput("ExImm", ExImm, mEx.imm);
        checkOutput("ExDestReg", 32'(ExDestReg), 32'(mEx.dest));
        checkOutput("ExRegWrite", 32'(ExRegWrite), 32'(mEx.regWrite));
        checkOutput("ExMemRead", 32'(ExMemRead), 32'(mEx.memRead));
        checkOutput("ExMemWrite", 32'(ExMemWrite), 32'(mEx.memWrite));
        checkOutput("ExOpcode", 32'(ExOpcode), 32'(mEx.opcode));
        checkOutput("ExFunct", 32'(ExFunct), 32'(mEx.funct));
        checkOutput("ExIllegal", 32'(ExIllegal), 32'(mEx.illegal));
      end
    end
  end

  // One cycle of stimulus, driven just after the rising edge.
  task automatic applyStimulus(input logic [31:0] ins, input logic valid,
                               input logic exRdy, input logic flush);
    @(posedge Clk);
    #1;
    Instr      = ins;
    InstrValid = valid;
    ExReady    = exRdy;
    Flush      = flush;
  endtask

  task automatic idleCycle();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  localparam logic [31:0] I_ADDI_R12 = 32'h200C002A;
  localparam logic [31:0] I_ORI_R8   = 32'h3408FFFF;
  localparam logic [31:0] I_LW_R2    = 32'h8C220000;
  localparam logic [31:0] I_ADD_DEP  = 32'h00441820;
  localparam logic [31:0] I_ADD_IND  = 32'h00241820;
  localparam logic [31:0] I_ADDI_R7  = 32'h20070001;
  localparam logic [31:0] I_ADDI_R0  = 32'h20000005;
  localparam logic [31:0] I_JAL      = 32'h0C000010;
  localparam logic [31:0] I_ILLEGAL  = 32'hFC000000;
  localparam logic [31:0] I_LUI_R9   = 32'h3C091234;
  localparam logic [31:0] I_SW       = 32'hAC22FFFC;
  localparam logic [31:0] I_ADD_R6   = 32'h00A53020;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
    regs[0]         = 32'h0;
    regs[5]         = 32'd7;
    reset           = 1'b1;
    Instr           = 32'h0;
    InstrValid      = 1'b0;
    ExReady         = 1'b1;
    Flush           = 1'b0;
    WbRegWrite      = 1'b0;
    WbWriteRegister = 5'd0;
    WbWriteData     = 32'h0;

    // Reset held for two cycles, then released.
    repeat (2) @(posedge Clk);
    #1 reset = 1'b0;
    @(negedge Clk);
    checkOutput("rst_ExValid", 32'(ExValid), 32'h0);
    checkOutput("rst_StallCount", 32'(StallCount), 32'h0);
    checkOutput("rst_ExOpA", ExOpA, 32'h0);
    checkOutput("rst_ExOpB", ExOpB, 32'h0);
    checkOutput("rst_ExImm", ExImm, 32'h0);
    checkOutput("rst_ExDestReg", 32'(ExDestReg), 32'h0);
    checkOutput("rst_ExRegWrite", 32'(ExRegWrite), 32'h0);
    checkOutput("rst_ExMemRead", 32'(ExMemRead), 32'h0);
    checkOutput("rst_ExMemWrite", 32'(ExMemWrite), 32'h0);
    checkOutput("rst_ExOpcode", 32'(ExOpcode), 32'h0);
    checkOutput("rst_ExFunct", 32'(ExFunct), 32'h0);
    checkOutput("rst_ExIllegal", 32'(ExIllegal), 32'h0);

    // ADDI r12,r0,42 then ORI r8,r0,0xFFFF.
    applyStimulus(I_ADDI_R12, 1'b1, 1'b1, 1'b0);
    idleCycle();
    @(negedge Clk);
    checkOutput("addi_valid", 32'(ExValid), 32'h1);
    checkOutput("addi_dest", 32'(ExDestReg), 32'd12);
    checkOutput("addi_regwrite", 32'(ExRegWrite), 32'h1);
    checkOutput("addi_imm", ExImm, 32'd42);
    applyStimulus(I_ORI_R8, 1'b1, 1'b1, 1'b0);
    idleCycle();
    @(negedge Clk);
    checkOutput("ori_imm", ExImm, 32'h0000FFFF);

    // Load-use: LW r2 then ADD r3,r2,r4 gets exactly one bubble.
    applyStimulus(I_LW_R2, 1'b1, 1'b1, 1'b0);
    applyStimulus(I_ADD_DEP, 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    checkOutput("loaduse_ready_low", 32'(InstrReady), 32'h0);
    applyStimulus(I_ADD_DEP, 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    checkOutput("loaduse_ready_back", 32'(InstrReady), 32'h1);
    checkOutput("loaduse_bubble", 32'(ExValid), 32'h0);
    idleCycle();
    @(negedge Clk);
    checkOutput("loaduse_add_dest", 32'(ExDestReg), 32'd3);
    checkOutput("loaduse_stallcount", 32'(StallCount), 32'd1);

    // Same pair with an independent ADD: no stall.
    applyStimulus(I_LW_R2, 1'b1, 1'b1, 1'b0);
    applyStimulus(I_ADD_IND, 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    checkOutput("nodep_ready", 32'(InstrReady), 32'h1);
    idleCycle();
    @(negedge Clk);
    checkOutput("nodep_stallcount", 32'(StallCount), 32'd1);

    // Execute back-pressure for three cycles, then a flush.
    applyStimulus(I_ADDI_R7, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(I_ORI_R8, 1'b1, 1'b0, 1'b0);
      @(negedge Clk);
      checkOutput("hold_ready", 32'(InstrReady), 32'h0);
      checkOutput("hold_dest", 32'(ExDestReg), 32'd7);
      checkOutput("hold_valid", 32'(ExValid), 32'h1);
    end
    applyStimulus(I_ORI_R8, 1'b1, 1'b0, 1'b1);
    @(negedge Clk);
    checkOutput("flush_ready", 32'(InstrReady), 32'h0);
    applyStimulus(I_ORI_R8, 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    checkOutput("flush_valid", 32'(ExValid), 32'h0);
    idleCycle();
    @(negedge Clk);
    checkOutput("after_flush_dest", 32'(ExDestReg), 32'd8);

    // Decode corner cases.
    applyStimulus(I_ADDI_R0, 1'b1, 1'b1, 1'b0);
    idleCycle();
    @(negedge Clk);
    checkOutput("r0_regwrite", 32'(ExRegWrite), 32'h0);
    applyStimulus(I_JAL, 1'b1, 1'b1, 1'b0);
    idleCycle();
    @(negedge Clk);
    checkOutput("jal_dest", 32'(ExDestReg), 32'd31);
    checkOutput("jal_regwrite", 32'(ExRegWrite), 32'h1);
    applyStimulus(I_ILLEGAL, 1'b1, 1'b1, 1'b0);
    idleCycle();
    @(negedge Clk);
    checkOutput("illegal_flag", 32'(ExIllegal), 32'h1);
    checkOutput("illegal_regwrite", 32'(ExRegWrite), 32'h0);
    applyStimulus(I_LUI_R9, 1'b1, 1'b1, 1'b0);
    idleCycle();
    @(negedge Clk);
    checkOutput("lui_imm", ExImm, 32'h12340000);
    applyStimulus(I_SW, 1'b1, 1'b1, 1'b0);
    idleCycle();
    @(negedge Clk);
    checkOutput("sw_imm", ExImm, 32'hFFFFFFFC);
    checkOutput("sw_memwrite", 32'(ExMemWrite), 32'h1);

    // Writeback to r5 in the same cycle as ADD r6,r5,r5.
    applyStimulus(I_ADD_R6, 1'b1, 1'b1, 1'b0);
    WbRegWrite      = 1'b1;
    WbWriteRegister = 5'd5;
    WbWriteData     = 32'd99;
    idleCycle();
    WbRegWrite      = 1'b0;
    WbWriteRegister = 5'd0;
    WbWriteData     = 32'h0;
    @(negedge Clk);
`ifdef DECODE_WB_BYPASS_EN
    checkOutput("bypass_opA", ExOpA, 32'd99);
    checkOutput("bypass_opB", ExOpB, 32'd99);
`else
    checkOutput("nobypass_opA", ExOpA, 32'd7);
    checkOutput("nobypass_opB", ExOpB, 32'd7);
`endif

    idleCycle();
    @(negedge Clk);
    running = 1'b0;
    repeat (2) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
